// File: rtl/mfp_sevenseg_scanner.sv
// mfp_sevenseg_scanner
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// Each digit slot is a blanking gap (all anodes off, against ghosting) followed
// by a dwell in which one anode is driven with the decoded glyph. Digit inputs
// are snapshotted at the end of the gap, so mid-dwell changes show up in the
// next slot of that digit. A one-cycle frame pulse follows the digit-7 dwell.

module mfp_sevenseg_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [7:0]  EN,
    input  logic [63:0] DIGITS,
    input  logic [7:0]  DP,
    output logic [7:0]  DISPENOUT,
    output logic [7:0]  DISPOUT,
    output logic        FRAME_TICK
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);
    localparam cnt_t DWELL_LAST = cnt_t'(DWELL_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] anode_q, anode_d;
    logic [7:0] seg_q, seg_d;
    logic       frame_tick_q, frame_tick_d;

    logic [4:0] code;
    logic       unused_digit_bits;

    // Bits [7:5] of every digit byte carry no meaning for the glyph decoder.
    assign unused_digit_bits = ^{DIGITS[63:61], DIGITS[55:53], DIGITS[47:45], DIGITS[39:37],
                                 DIGITS[31:29], DIGITS[23:21], DIGITS[15:13], DIGITS[7:5]};

    assign code = DIGITS[{idx_q, 3'b000} +: 5];

    // Active-high segment pattern {g,f,e,d,c,b,a} for a 5-bit glyph code.
    function automatic logic [6:0] seg_decode(input logic [4:0] c);
        logic [6:0] s;
        case (c)
            5'h00: s = 7'h3F;
            5'h01: s = 7'h06;
            5'h02: s = 7'h5B;
            5'h03: s = 7'h4F;
            5'h04: s = 7'h66;
            5'h05: s = 7'h6D;
            5'h06: s = 7'h7D;
            5'h07: s = 7'h07;
            5'h08: s = 7'h7F;
            5'h09: s = 7'h6F;
            5'h0A: s = 7'h77;
            5'h0B: s = 7'h7C;
            5'h0C: s = 7'h39;
            5'h0D: s = 7'h5E;
            5'h0E: s = 7'h79;
            5'h0F: s = 7'h71;
            5'h10: s = 7'h40;
            5'h11: s = 7'h08;
            5'h12: s = 7'h7F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next-state logic: slot counter, digit index, snapshot of the driven digit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        anode_d      = anode_q;
        seg_d        = seg_q;
        frame_tick_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                anode_d = 8'hFF;
                seg_d   = 8'hFF;
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    anode_d = EN[idx_q] ? 8'hFF : ~(8'h01 << idx_q);
                    seg_d   = {DP[idx_q], ~seg_decode(code)};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d      = ST_BLANK;
                    cnt_d        = '0;
                    idx_d        = idx_q + 3'd1;
                    anode_d      = 8'hFF;
                    seg_d        = 8'hFF;
                    frame_tick_d = (idx_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_BLANK;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            anode_q      <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign DISPENOUT  = anode_q;
    assign DISPOUT    = seg_q;
    assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_mfp_sevenseg_scanner.sv
// Self-checking bench for mfp_sevenseg_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2.
// Slot timing after reset release: digit k is driven from edge 2+6k for 4 cycles,
// then 2 blank cycles; the frame pulse follows edge 48.

module tb_mfp_sevenseg_scanner;

    logic        clk;
    logic        rst;
    logic [7:0]  en;
    logic [63:0] digits;
    logic [7:0]  dp;
    logic [7:0]  dispenout;
    logic [7:0]  dispout;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    mfp_sevenseg_scanner #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .EN        (en),
        .DIGITS    (digits),
        .DP        (dp),
        .DISPENOUT (dispenout),
        .DISPOUT   (dispout),
        .FRAME_TICK(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       en;
        logic [63:0]      digits;
        logic [7:0]       dp;
        logic [7:0][7:0]  exp_an;
        logic [7:0][7:0]  exp_disp;
        logic [7:0]       disp_chk;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset, load inputs, release on a falling edge (edge count restarts at 0).
    task automatic do_reset(input logic [7:0] e, input logic [63:0] d, input logic [7:0] p);
        @(negedge clk);
        rst = 1'b1;
        en = e;
        digits = d;
        dp = p;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // At most one anode may ever be low.
    always @(negedge clk) begin
        if (!rst) check("one_anode", 8'($countones(~dispenout) > 1), 8'h00);
    end

    initial begin
        rst = 1'b1;
        en = 8'h00;
        digits = 64'h0;
        dp = 8'hFF;

        vecs[0].en       = 8'h00;
        vecs[0].digits   = 64'h0706050403020100;
        vecs[0].dp       = 8'hFF;
        vecs[0].exp_an   = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        vecs[0].exp_disp = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        vecs[0].disp_chk = 8'hFF;

        vecs[1].en       = 8'hF0;
        vecs[1].digits   = 64'h1212121212121212;
        vecs[1].dp       = 8'hF7;
        vecs[1].exp_an   = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        vecs[1].exp_disp = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h80};
        vecs[1].disp_chk = 8'h0F;

        vecs[2].en       = 8'h00;
        vecs[2].digits   = 64'h0D0C0B0A131F1110;
        vecs[2].dp       = 8'hFF;
        vecs[2].exp_an   = vecs[0].exp_an;
        vecs[2].exp_disp = {8'hA1, 8'hC6, 8'h83, 8'h88, 8'hFF, 8'hFF, 8'hF7, 8'hBF};
        vecs[2].disp_chk = 8'hFF;

        vecs[3].en       = 8'h00;
        vecs[3].digits   = 64'h060513120F0E0908;
        vecs[3].dp       = 8'hAA;
        vecs[3].exp_an   = vecs[0].exp_an;
        vecs[3].exp_disp = {8'h82, 8'h12, 8'hFF, 8'h00, 8'h8E, 8'h06, 8'h90, 8'h00};
        vecs[3].disp_chk = 8'hFF;

        // Reset state while held, then first drive at the second edge.
        repeat (3) @(negedge clk);
        check("rst_an", dispenout, 8'hFF);
        check("rst_disp", dispout, 8'hFF);
        check("rst_tick", {7'd0, frame_tick}, 8'h00);
        rst = 1'b0;
        step(1);
        check("rel_e1_an", dispenout, 8'hFF);
        step(1);
        check("rel_e2_an", dispenout, 8'hFE);

        // Full frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            do_reset(vecs[v].en, vecs[v].digits, vecs[v].dp);
            step(2);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("v%0d_d%0d_an", v, k), dispenout, vecs[v].exp_an[k]);
                if (vecs[v].disp_chk[k])
                    check($sformatf("v%0d_d%0d_disp", v, k), dispout, vecs[v].exp_disp[k]);
                check($sformatf("v%0d_d%0d_tick_lo", v, k), {7'd0, frame_tick}, 8'h00);
                step(3);
                check($sformatf("v%0d_d%0d_an_hold", v, k), dispenout, vecs[v].exp_an[k]);
                step(1);
                check($sformatf("v%0d_d%0d_blank_an", v, k), dispenout, 8'hFF);
                check($sformatf("v%0d_d%0d_blank_disp", v, k), dispout, 8'hFF);
                check($sformatf("v%0d_d%0d_tick", v, k), {7'd0, frame_tick}, (k == 7) ? 8'h01 : 8'h00);
                step(2);
            end
        end

        // Frame pulse spacing: pulses at edges 48 and 96 only.
        do_reset(8'h00, 64'h0706050403020100, 8'hFF);
        step(47);
        check("tick_e47", {7'd0, frame_tick}, 8'h00);
        step(1);
        check("tick_e48", {7'd0, frame_tick}, 8'h01);
        step(1);
        check("tick_e49", {7'd0, frame_tick}, 8'h00);
        step(46);
        check("tick_e95", {7'd0, frame_tick}, 8'h00);
        step(1);
        check("tick_e96", {7'd0, frame_tick}, 8'h01);

        // Mid-dwell input change shows only in the next slot of that digit.
        do_reset(8'h00, 64'h0706050403020100, 8'hFF);
        step(14);
        check("snap_d2_an", dispenout, 8'hFB);
        check("snap_d2_disp", dispout, 8'hA4);
        digits[23:16] = 8'h08;
        step(3);
        check("snap_d2_hold", dispout, 8'hA4);
        step(45);
        check("snap_next_an", dispenout, 8'hFB);
        check("snap_next_disp", dispout, 8'h80);

        // Asynchronous reset in the middle of the digit-5 dwell.
        do_reset(8'h00, 64'h0706050403020100, 8'hFF);
        step(33);
        check("ar_d5_an", dispenout, 8'hDF);
        check("ar_d5_disp", dispout, 8'h92);
        #2;
        rst = 1'b1;
        #1;
        check("ar_an", dispenout, 8'hFF);
        check("ar_disp", dispout, 8'hFF);
        check("ar_tick", {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("ar_e1_an", dispenout, 8'hFF);
        step(1);
        check("ar_e2_an", dispenout, 8'hFE);
        check("ar_e2_disp", dispout, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
